// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC generation, request/response memory port,
// one-entry hold buffer behind the IF/ID output slot, redirect squashing.
module inst_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic              imemReady,
  input  logic              imemRvalid,
  input  logic [INST_W-1:0] imemRdata,
  input  logic              brTaken,
  input  logic [ADDR_W-1:0] brTarget,
  input  logic              idStall,
  output logic              ifValid,
  output logic [ADDR_W-1:0] ifPC,
  output logic [INST_W-1:0] ifInst
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc, fetch_pc_nxt;
  logic [ADDR_W-1:0] req_pc, req_pc_nxt;
  logic              drop, drop_nxt;
  logic              out_valid_nxt;
  logic [ADDR_W-1:0] out_pc_nxt;
  logic [INST_W-1:0] out_inst_nxt;
  logic              hold_valid, hold_valid_nxt;
  logic [ADDR_W-1:0] hold_pc, hold_pc_nxt;
  logic [INST_W-1:0] hold_inst, hold_inst_nxt;
  logic              accept_c;
  logic              resp_c;

  assign accept_c = (state == REQ) && imemReady;
  assign resp_c   = (state == WAIT) && imemRvalid;
  assign imemAddr = req_pc;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      req_pc     <= RESET_PC;
      drop       <= 1'b0;
      imemReq    <= 1'b0;
      ifValid    <= 1'b0;
      ifPC       <= '0;
      ifInst     <= '0;
      hold_valid <= 1'b0;
      hold_pc    <= '0;
      hold_inst  <= '0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      req_pc     <= req_pc_nxt;
      drop       <= drop_nxt;
      imemReq    <= (state_nxt == REQ);
      ifValid    <= out_valid_nxt;
      ifPC       <= out_pc_nxt;
      ifInst     <= out_inst_nxt;
      hold_valid <= hold_valid_nxt;
      hold_pc    <= hold_pc_nxt;
      hold_inst  <= hold_inst_nxt;
    end
  end

  // Next-state, response steering, consumption and redirect
  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    req_pc_nxt     = req_pc;
    drop_nxt       = drop;
    out_valid_nxt  = ifValid;
    out_pc_nxt     = ifPC;
    out_inst_nxt   = ifInst;
    hold_valid_nxt = hold_valid;
    hold_pc_nxt    = hold_pc;
    hold_inst_nxt  = hold_inst;

    // A request already squashed while waiting for ready keeps the redirect target
    if (accept_c && !brTaken && !drop) begin
      fetch_pc_nxt = req_pc + ADDR_W'(4);
    end

    if (brTaken) begin
      fetch_pc_nxt   = brTarget & ~ADDR_W'(3);
      out_valid_nxt  = 1'b0;
      hold_valid_nxt = 1'b0;
      if ((state == REQ) || ((state == WAIT) && !imemRvalid)) begin
        drop_nxt = 1'b1;
      end else if (resp_c) begin
        drop_nxt = 1'b0;
      end
    end else begin
      if (resp_c) begin
        drop_nxt = 1'b0;
      end
      if (resp_c && !drop) begin
        if (!ifValid || !idStall) begin
          out_valid_nxt = 1'b1;
          out_pc_nxt    = req_pc;
          out_inst_nxt  = imemRdata;
        end else begin
          hold_valid_nxt = 1'b1;
          hold_pc_nxt    = req_pc;
          hold_inst_nxt  = imemRdata;
        end
      end else if (ifValid && !idStall) begin
        if (hold_valid) begin
          out_pc_nxt     = hold_pc;
          out_inst_nxt   = hold_inst;
          hold_valid_nxt = 1'b0;
        end else begin
          out_valid_nxt = 1'b0;
        end
      end
    end

    case (state)
      IDLE:    if (!hold_valid_nxt) state_nxt = REQ;
      REQ:     if (imemReady) state_nxt = WAIT;
      WAIT:    if (imemRvalid) state_nxt = hold_valid_nxt ? IDLE : REQ;
      default: state_nxt = IDLE;
    endcase

    if ((state_nxt == REQ) && (state != REQ)) begin
      req_pc_nxt = fetch_pc_nxt;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Scoreboard bench for inst_fetch: a memory responder with random latency,
// random stalls and redirects, checked against an expected in-order PC stream.
module tb_inst_fetch;
  localparam int unsigned       AW  = 32;
  localparam int unsigned       IW  = 32;
  localparam logic [AW-1:0]     RPC = 32'h0000_0000;

  logic          clk, rst;
  logic          imemReq, imemReady, imemRvalid;
  logic [AW-1:0] imemAddr;
  logic [IW-1:0] imemRdata;
  logic          brTaken, idStall;
  logic [AW-1:0] brTarget;
  logic          ifValid;
  logic [AW-1:0] ifPC;
  logic [IW-1:0] ifInst;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_deliv = 0;

  logic [AW-1:0] exp_q[$];
  bit            fast;
  bit            pend;
  logic [AW-1:0] paddr;
  int            dly;
  bit            mon_en;

  inst_fetch #(.ADDR_W(AW), .INST_W(IW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst(rst),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemReady(imemReady),
    .imemRvalid(imemRvalid), .imemRdata(imemRdata),
    .brTaken(brTaken), .brTarget(brTarget), .idStall(idStall),
    .ifValid(ifValid), .ifPC(ifPC), .ifInst(ifInst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    end
  endtask

  // Expected program-order stream restarts at an aligned PC and counts up by 4
  task automatic restart_model(input logic [AW-1:0] pc);
    exp_q.delete();
    exp_q.push_back(pc & ~32'h3);
    while (exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd4);
  endtask

  task automatic cycle(input bit br, input logic [AW-1:0] tgt, input bit stall);
    @(negedge clk);
    if (imemReq && imemReady) begin
      pend  = 1'b1;
      paddr = imemAddr;
      dly   = fast ? 0 : int'($urandom_range(0, 3));
    end else if (imemRvalid) begin
      pend = 1'b0;
    end
    @(posedge clk);
    #1;
    imemRvalid = 1'b0;
    imemRdata  = $urandom;
    if (pend) begin
      if (dly == 0) begin
        imemRvalid = 1'b1;
        imemRdata  = mem_word(paddr);
      end else begin
        dly--;
      end
    end
    imemReady = fast ? 1'b1 : 1'($urandom_range(0, 1));
    idStall   = stall;
    brTaken   = br;
    brTarget  = tgt;
    if (br) restart_model(tgt);
    while (exp_q.size() < 8) exp_q.push_back(exp_q[$] + 32'd4);
  endtask

  task automatic do_reset(input bit stale);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk(ifValid == 1'b0, "rst_ifValid", 32'(ifValid), 32'd0);
    chk(ifPC == '0, "rst_ifPC", ifPC, 32'd0);
    chk(ifInst == '0, "rst_ifInst", ifInst, 32'd0);
    chk(imemReq == 1'b0, "rst_imemReq", 32'(imemReq), 32'd0);
    chk(imemAddr == RPC, "rst_imemAddr", imemAddr, RPC);
    pend = 1'b0; imemRvalid = 1'b0; imemReady = 1'b0; brTaken = 1'b0; idStall = 1'b0;
    restart_model(RPC);
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    if (stale) begin
      imemRvalid = 1'b1;
      imemRdata  = 32'hDEAD_BEEF;
    end
  endtask

  // Monitor: pops the expected stream on every handshake and checks hold/protocol rules
  bit            p_hold, p_br, p_req;
  logic [AW-1:0] p_pc, p_addr, e;
  logic [IW-1:0] p_inst;
  int            idle_cyc;

  always @(negedge clk) begin
    if (!mon_en || !rst) begin
      p_hold = 1'b0; p_br = 1'b0; p_req = 1'b0; idle_cyc = 0;
    end else begin
      if (p_br) chk(ifValid == 1'b0, "valid_after_redirect", 32'(ifValid), 32'd0);
      if (p_hold) begin
        chk(ifValid == 1'b1, "stall_valid", 32'(ifValid), 32'd1);
        chk(ifPC == p_pc, "stall_pc", ifPC, p_pc);
        chk(ifInst == p_inst, "stall_inst", ifInst, p_inst);
      end
      if (p_req) begin
        chk(imemReq == 1'b1, "req_held", 32'(imemReq), 32'd1);
        chk(imemAddr == p_addr, "addr_held", imemAddr, p_addr);
      end
      if (imemReq) chk((imemAddr & 32'h3) == 32'h0, "addr_align", imemAddr, imemAddr & ~32'h3);
      if (ifValid && !idStall && !brTaken) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "sb_empty", ifPC, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk(ifPC == e, "if_pc", ifPC, e);
          chk(ifInst == mem_word(e), "if_inst", ifInst, mem_word(e));
        end
        n_deliv++;
        idle_cyc = 0;
      end else begin
        idle_cyc++;
        if (idle_cyc > 200) begin
          chk(1'b0, "deliver_timeout", 32'(idle_cyc), 32'd200);
          idle_cyc = 0;
        end
      end
      p_br   = brTaken;
      p_hold = ifValid && idStall && !brTaken;
      p_pc   = ifPC;
      p_inst = ifInst;
      p_req  = imemReq && !imemReady;
      p_addr = imemAddr;
    end
  end

  initial begin
    logic [AW-1:0] tgt;
    int            sel;
    rst = 1'b1; imemReady = 1'b0; imemRvalid = 1'b0; imemRdata = '0;
    brTaken = 1'b0; brTarget = '0; idStall = 1'b0;
    fast = 1'b1; pend = 1'b0; dly = 0; paddr = '0; mon_en = 1'b0;
    restart_model(RPC);

    // Best-case latency and sequential fetch
    do_reset(1'b0);
    cycle(1'b0, '0, 1'b0);
    chk(imemReq == 1'b1, "c1_imemReq", 32'(imemReq), 32'd1);
    chk(imemAddr == RPC, "c1_imemAddr", imemAddr, RPC);
    cycle(1'b0, '0, 1'b0);
    chk(ifValid == 1'b0, "c2_ifValid", 32'(ifValid), 32'd0);
    cycle(1'b0, '0, 1'b0);
    chk(ifValid == 1'b1, "c3_ifValid", 32'(ifValid), 32'd1);
    chk(ifPC == RPC, "c3_ifPC", ifPC, RPC);
    repeat (2) cycle(1'b0, '0, 1'b0);
    chk(ifValid && (ifPC == RPC + 32'd4), "c5_ifPC", ifPC, RPC + 32'd4);
    repeat (2) cycle(1'b0, '0, 1'b0);
    chk(ifValid && (ifPC == RPC + 32'd8), "c7_ifPC", ifPC, RPC + 32'd8);

    // Stall fill: slot + hold buffer full, no further request
    do_reset(1'b0);
    repeat (12) cycle(1'b0, '0, 1'b1);
    chk(ifValid == 1'b1, "fill_ifValid", 32'(ifValid), 32'd1);
    chk(ifPC == RPC, "fill_ifPC", ifPC, RPC);
    chk(imemReq == 1'b0, "fill_imemReq", 32'(imemReq), 32'd0);
    repeat (10) cycle(1'b0, '0, 1'b0);

    // Async reset with both entries full, then a stale response
    repeat (8) cycle(1'b0, '0, 1'b1);
    chk(ifValid == 1'b1, "prerst_ifValid", 32'(ifValid), 32'd1);
    do_reset(1'b1);
    repeat (8) cycle(1'b0, '0, 1'b0);

    // Directed redirects: wrap-around and unaligned target
    cycle(1'b1, 32'hFFFF_FFFC, 1'b0);
    repeat (8) cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 32'h0000_0103, 1'b0);
    repeat (8) cycle(1'b0, '0, 1'b0);

    // Randomised traffic
    fast = 1'b0;
    repeat (3000) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       tgt = $urandom;
        1:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        2:       tgt = 32'h0000_0103;
        default: tgt = 32'h0000_0200;
      endcase
      cycle(($urandom_range(0, 99) < 4), tgt, ($urandom_range(0, 99) < 30));
    end
    fast = 1'b1;
    repeat (20) cycle(1'b0, '0, 1'b0);
    chk(n_deliv > 500, "progress", 32'(n_deliv), 32'd500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
